// File: rtl/wb_regbank.sv
// Write-back stage: selects MEM/WB result and destination, commits into a 32x32 register
// bank, serves two bypassed read ports, and keeps a one-cycle forwarding history and a write counter.
module wb_regbank #(
  parameter int NREGS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_wb_hold,
  input  logic [31:0] dato_mem_out,
  input  logic [31:0] ALU_out,
  input  logic [4:0]  rd_out,
  input  logic [4:0]  rt_out,
  input  logic        Mux_flag_2_MOUT,
  input  logic        Mux_flag_3_MOUT,
  input  logic        banco_flag_wr_MOUT,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data,
  output logic [31:0] wb_count
);

  logic [31:0] wdata;
  logic [4:0]  wdest;
  logic        we;
  logic [31:0] bank_q [NREGS];

  logic        fwd_valid_reg;
  logic [4:0]  fwd_dest_reg;
  logic [31:0] fwd_data_reg;
  logic [31:0] count_reg;

  assign wdata = Mux_flag_2_MOUT ? dato_mem_out : ALU_out;
  assign wdest = Mux_flag_3_MOUT ? rd_out : rt_out;
  // rst_n in the enable keeps the bypass dead during reset; ~hold masks any X/Z on the data inputs.
  assign we    = rst_n & banco_flag_wr_MOUT & ~mem_wb_hold & (wdest != 5'd0);

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign bank_q[gi] = 32'd0;
      end else begin : g_flop
        logic [31:0] q_reg;
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            q_reg <= 32'd0;
          end else if (we && (wdest == 5'(gi))) begin
            q_reg <= wdata;
          end
        end
        assign bank_q[gi] = q_reg;
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [4:0]  addr;
      logic [31:0] data;
      assign addr = (gi == 0) ? ra_addr : rb_addr;
      assign data = (addr == 5'd0)              ? 32'd0 :
                    (we && (wdest == addr))     ? wdata :
                                                  bank_q[addr];
    end
  endgenerate

  assign ra_data = g_port[0].data;
  assign rb_data = g_port[1].data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_reg <= 1'b0;
      fwd_dest_reg  <= 5'd0;
      fwd_data_reg  <= 32'd0;
      count_reg     <= 32'd0;
    end else begin
      fwd_valid_reg <= we;
      if (we) begin
        fwd_dest_reg <= wdest;
        fwd_data_reg <= wdata;
        count_reg    <= count_reg + 32'd1;
      end
    end
  end

  assign fwd_valid = fwd_valid_reg;
  assign fwd_dest  = fwd_dest_reg;
  assign fwd_data  = fwd_data_reg;
  assign wb_count  = count_reg;

endmodule

// File: tb/tb_wb_regbank.sv
// Directed bench for wb_regbank: expectations are queued when stimulus is driven and
// popped in order against sampled outputs.
module tb_wb_regbank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_wb_hold = 1'b0;
  logic [31:0] dato_mem_out = 32'd0;
  logic [31:0] ALU_out = 32'd0;
  logic [4:0]  rd_out = 5'd0;
  logic [4:0]  rt_out = 5'd0;
  logic        Mux_flag_2_MOUT = 1'b0;
  logic        Mux_flag_3_MOUT = 1'b0;
  logic        banco_flag_wr_MOUT = 1'b0;
  logic [4:0]  ra_addr = 5'd0;
  logic [4:0]  rb_addr = 5'd0;
  logic [31:0] ra_data, rb_data, fwd_data, wb_count;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;

  wb_regbank #(.NREGS(32)) dut (
    .clk(clk), .rst_n(rst_n), .mem_wb_hold(mem_wb_hold),
    .dato_mem_out(dato_mem_out), .ALU_out(ALU_out),
    .rd_out(rd_out), .rt_out(rt_out),
    .Mux_flag_2_MOUT(Mux_flag_2_MOUT), .Mux_flag_3_MOUT(Mux_flag_3_MOUT),
    .banco_flag_wr_MOUT(banco_flag_wr_MOUT),
    .ra_addr(ra_addr), .rb_addr(rb_addr),
    .ra_data(ra_data), .rb_data(rb_data),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
    .wb_count(wb_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        fails++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
      $display("[TB] %s observed=%h expected=%h", e.tag, obs, e.val);
    end
  endtask

  // Present one MEM/WB beat (as the falling-edge pipeline register would).
  task automatic drive(input logic wr, input logic m2, input logic m3,
                       input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] rd, input logic [4:0] rt);
    mem_wb_hold        = 1'b0;
    banco_flag_wr_MOUT = wr;
    Mux_flag_2_MOUT    = m2;
    Mux_flag_3_MOUT    = m3;
    dato_mem_out       = mem;
    ALU_out            = alu;
    rd_out             = rd;
    rt_out             = rt;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a write presented: nothing may leak through bypass or commit.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hAAAA5555, 5'd5, 5'd0);
    #2;
    for (int a = 0; a < 32; a++) begin
      ra_addr = 5'(a);
      rb_addr = 5'(31 - a);
      expect_val($sformatf("rst_ra_r%0d", a), 32'd0);
      expect_val($sformatf("rst_rb_r%0d", 31 - a), 32'd0);
      #1;
      check(ra_data);
      check(rb_data);
    end
    @(posedge clk); #1;
    expect_val("rst_count", 32'd0);      check(wb_count);
    expect_val("rst_fwd_valid", 32'd0);  check(32'(fwd_valid));
    expect_val("rst_fwd_dest", 32'd0);   check(32'(fwd_dest));
    expect_val("rst_fwd_data", 32'd0);   check(fwd_data);

    // Release reset with the ALU write to r5 presented.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h12345678, 5'd5, 5'd0);
    ra_addr = 5'd5; rb_addr = 5'd5;
    expect_val("alu_byp_a", 32'h12345678);
    expect_val("alu_byp_b", 32'h12345678);
    expect_val("alu_count_pre", 32'd0);
    #1; check(ra_data); check(rb_data); check(wb_count);
    @(posedge clk); #1;
    expect_val("alu_fwd_valid", 32'd1);  check(32'(fwd_valid));
    expect_val("alu_fwd_dest", 32'd5);   check(32'(fwd_dest));
    expect_val("alu_fwd_data", 32'h12345678); check(fwd_data);
    expect_val("alu_count", 32'd1);      check(wb_count);

    // Memory path to r9 via rt; r5 now comes from the bank.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0BAD0BAD, 5'd5, 5'd9);
    ra_addr = 5'd5; rb_addr = 5'd9;
    expect_val("mem_bank_r5", 32'h12345678);
    expect_val("mem_byp_r9", 32'hDEADBEEF);
    #1; check(ra_data); check(rb_data);
    @(posedge clk); #1;
    expect_val("mem_count", 32'd2);      check(wb_count);
    expect_val("mem_fwd_dest", 32'd9);   check(32'(fwd_dest));
    expect_val("mem_fwd_data", 32'hDEADBEEF); check(fwd_data);

    // Idle cycle: history still valid until the next edge, then only valid drops.
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    ra_addr = 5'd9; rb_addr = 5'd5;
    expect_val("idle_r9", 32'hDEADBEEF);
    expect_val("idle_r5", 32'h12345678);
    expect_val("idle_fwd_valid_pre", 32'd1);
    #1; check(ra_data); check(rb_data); check(32'(fwd_valid));
    @(posedge clk); #1;
    expect_val("idle_fwd_valid", 32'd0); check(32'(fwd_valid));
    expect_val("idle_fwd_dest", 32'd9);  check(32'(fwd_dest));
    expect_val("idle_fwd_data", 32'hDEADBEEF); check(fwd_data);
    expect_val("idle_count", 32'd2);     check(wb_count);

    // Suppression: destination r0.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hFFFFFFFF, 5'd0, 5'd9);
    ra_addr = 5'd0; rb_addr = 5'd9;
    expect_val("r0_read", 32'd0);
    expect_val("r0_r9_kept", 32'hDEADBEEF);
    #1; check(ra_data); check(rb_data);
    @(posedge clk); #1;
    expect_val("r0_count", 32'd2);       check(wb_count);
    expect_val("r0_fwd_valid", 32'd0);   check(32'(fwd_valid));
    expect_val("r0_read_after", 32'd0);  check(ra_data);

    // Suppression: hold with data inputs floating.
    @(negedge clk);
    mem_wb_hold = 1'b1;
    banco_flag_wr_MOUT = 1'b1;
    dato_mem_out = 'z; ALU_out = 'z; rd_out = 'z; rt_out = 'z;
    ra_addr = 5'd5; rb_addr = 5'd9;
    expect_val("hold_r5", 32'h12345678);
    expect_val("hold_r9", 32'hDEADBEEF);
    #1; check(ra_data); check(rb_data);
    @(posedge clk); #1;
    expect_val("hold_count", 32'd2);     check(wb_count);
    expect_val("hold_fwd_valid", 32'd0); check(32'(fwd_valid));
    expect_val("hold_fwd_data", 32'hDEADBEEF); check(fwd_data);
    expect_val("hold_r5_after", 32'h12345678); check(ra_data);
    expect_val("hold_r9_after", 32'hDEADBEEF); check(rb_data);
    ra_addr = 5'd1; rb_addr = 5'd31;
    expect_val("hold_r1", 32'd0);
    expect_val("hold_r31", 32'd0);
    #1; check(ra_data); check(rb_data);

    // Back-to-back writes to r7 with both ports watching.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h1, 5'd7, 5'd0);
    ra_addr = 5'd7; rb_addr = 5'd7;
    expect_val("b2b1_a", 32'h1); expect_val("b2b1_b", 32'h1);
    #1; check(ra_data); check(rb_data);
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 32'h2, 32'h0, 5'd7, 5'd0);
    expect_val("b2b2_a", 32'h2); expect_val("b2b2_b", 32'h2);
    #1; check(ra_data); check(rb_data);
    @(posedge clk); #1;
    expect_val("b2b_count", 32'd4);      check(wb_count);
    expect_val("b2b_fwd_dest", 32'd7);   check(32'(fwd_dest));
    expect_val("b2b_fwd_data", 32'h2);   check(fwd_data);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    expect_val("b2b_bank_r7", 32'h2);
    #1; check(ra_data);

    // Async reset between edges with a write pending.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h55, 5'd3, 5'd0);
    ra_addr = 5'd7; rb_addr = 5'd3;
    #2;
    rst_n = 1'b0;
    #1;
    expect_val("arst_r7", 32'd0);        check(ra_data);
    expect_val("arst_r3_byp", 32'd0);    check(rb_data);
    expect_val("arst_count", 32'd0);     check(wb_count);
    expect_val("arst_fwd_valid", 32'd0); check(32'(fwd_valid));
    expect_val("arst_fwd_dest", 32'd0);  check(32'(fwd_dest));
    expect_val("arst_fwd_data", 32'd0);  check(fwd_data);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    @(posedge clk); #1;
    expect_val("arst_r3_discarded", 32'd0); check(rb_data);
    expect_val("arst_r9_cleared", 32'd0);
    ra_addr = 5'd9;
    #1; check(ra_data);

    // Counter wrap from all-ones.
    @(negedge clk);
    force dut.count_reg = 32'hFFFFFFFF;
    #1;
    release dut.count_reg;
    expect_val("wrap_preload", 32'hFFFFFFFF); check(wb_count);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, 5'd4, 5'd0);
    ra_addr = 5'd4;
    @(posedge clk); #1;
    expect_val("wrap_count", 32'd0);     check(wb_count);
    expect_val("wrap_fwd_valid", 32'd1); check(32'(fwd_valid));
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0);
    expect_val("wrap_bank_r4", 32'h0BADF00D);
    #1; check(ra_data);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
